// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// Purpose
//   SPI slave receiver. The SPI pins are brought into the system clock domain
//   through 2-flop synchronisers. Sampling and launch edges are detected on
//   the synchronised sclk. Serial words (MSB first) are assembled and pushed
//   into a small receive FIFO that is drained with a valid/ready handshake.
//   Supports all four SPI modes. The system clock must run at least 4x sclk.
//
// Optional feature
//   Define SPI_SLAVE_RX_ECHO_EN to enable the MISO echo. The slave then shifts
//   the most recently completed word back out on spi_miso. Without the macro,
//   spi_miso is tied to 0 and no TX register exists.
//
// Parameters
//   WORD_W     : bits per received word (8..32)
//   FIFO_DEPTH : receive FIFO entries (power of two, >= 2)
//   SPI_MODE   : 0..3, CPOL = bit 1, CPHA = bit 0
//
// Ports
//   clock     : system clock, all logic on the rising edge
//   reset     : synchronous, active-high reset
//   spi_sclk  : SPI clock (asynchronous to clock)
//   spi_mosi  : serial data in, MSB first
//   spi_cs    : chip select, active-low
//   spi_miso  : serial data out (echo feature, otherwise 0)
//   out_data  : FIFO head word
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts the head word
//   overflow  : one-cycle pulse when a completed word is dropped (FIFO full)
//   frame_err : one-cycle pulse when cs deasserts in the middle of a word
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SPI_MODE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              frame_err
);

  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];
  // Mode 0 and mode 3 sample on the rising edge. Mode 1 and mode 2 sample
  // on the falling edge.
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      ONE_CNT  = (AW + 1)'(1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Synchroniser bit order is {cs, sclk, mosi}. The idle levels keep the
  // edge detector quiet when reset is released.
  localparam logic [2:0] SYNC_IDLE = {1'b1, CPOL, 1'b0};

  // ---------------------------------------------------------------------------
  // Input synchronisers and sclk edge detection
  // ---------------------------------------------------------------------------
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic       sclk_prev_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg     <= SYNC_IDLE;
      sync2_reg     <= SYNC_IDLE;
      sclk_prev_reg <= CPOL;
    end else begin
      sync1_reg     <= {spi_cs, spi_sclk, spi_mosi};
      sync2_reg     <= sync1_reg;
      sclk_prev_reg <= sync2_reg[1];
    end
  end

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic sample_edge;

  assign cs_s   = sync2_reg[2];
  assign sclk_s = sync2_reg[1];
  assign mosi_s = sync2_reg[0];

  assign sclk_rise   = sclk_s & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_s & sclk_prev_reg;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

  // ---------------------------------------------------------------------------
  // Receive FSM and shift register
  // ---------------------------------------------------------------------------
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_next;
  // Only WORD_W-1 bits are held. The final bit goes straight into the
  // pushed word, so no register bit is left unread.
  logic [WORD_W-2:0] shift_reg;
  logic [WORD_W-2:0] shift_next;
  logic [WORD_W-1:0] shifted;
  logic              word_done;
  logic              frame_err_next;

  assign shifted = {shift_reg, mosi_s};

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    word_done      = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cs_s) begin
          state_next   = ACTIVE;
          bit_cnt_next = '0;
        end
      end
      default: begin
        if (cs_s) begin
          // A cs release takes priority over any edge in the same cycle.
          // A partial word is simply abandoned.
          state_next     = IDLE;
          bit_cnt_next   = '0;
          frame_err_next = (bit_cnt_reg != '0);
        end else if (sample_edge) begin
          shift_next = shifted[WORD_W-2:0];
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            word_done    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      frame_err     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      frame_err     <= frame_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_plus1;
  logic [AW:0]       count_reg;
  logic [WORD_W-1:0] head_reg;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              overflow_next;

  assign out_valid     = (count_reg != '0);
  assign out_data      = head_reg;
  assign pop           = out_valid & out_ready;
  assign full          = (count_reg == FULL_CNT);
  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle.
  assign push_ok       = word_done & (~full | pop);
  assign overflow_next = word_done & full & ~pop;
  assign rd_ptr_plus1  = rd_ptr_reg + 1'b1;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shifted;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= overflow_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_plus1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The head is a registered copy of mem[rd_ptr]. A pushed word bypasses
      // the array when it becomes the new head in the same cycle. When
      // count > 1 the next entry is already in the array. That entry is never
      // the slot being written this cycle.
      if (pop) begin
        if (count_reg != ONE_CNT) begin
          head_reg <= mem[rd_ptr_plus1];
        end else if (push_ok) begin
          head_reg <= shifted;
        end
      end else if (push_ok && (count_reg == '0)) begin
        head_reg <= shifted;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MISO echo
  // ---------------------------------------------------------------------------
`ifdef SPI_SLAVE_RX_ECHO_EN
  logic [WORD_W-1:0] last_word_reg;
  logic [WORD_W-1:0] tx_reg;
  logic              skip_reg;
  logic              launch_edge;
  logic              enter_active;

  assign launch_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign enter_active = (state_reg == IDLE) & ~cs_s;

  // skip_reg swallows the launch edge that does not belong to the freshly
  // loaded word. This happens in two cases:
  //  - At a word boundary, it is the trailing edge of the last bit (CPHA=0)
  //    or the leading edge of the first bit (CPHA=1). In both cases the MSB
  //    is already presented by the load.
  //  - On cs entry with CPHA=1, it is the first leading edge.
  // On cs entry with CPHA=0, no edge precedes the first sample, so nothing
  // is skipped.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_word_reg <= '0;
      tx_reg        <= '0;
      skip_reg      <= 1'b0;
    end else begin
      if (word_done) begin
        last_word_reg <= shifted;
        tx_reg        <= shifted;
        skip_reg      <= 1'b1;
      end else if (enter_active) begin
        tx_reg   <= last_word_reg;
        skip_reg <= CPHA;
      end else if (launch_edge && (state_reg == ACTIVE)) begin
        if (skip_reg) begin
          skip_reg <= 1'b0;
        end else begin
          tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso = (state_reg == ACTIVE) & tx_reg[WORD_W-1];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Purpose
//   Directed testbench for spi_slave_rx. It uses three instances:
//   - index 0: WORD_W=16, FIFO_DEPTH=4, SPI_MODE=0
//   - index 1: WORD_W=8, SPI_MODE=3
//   - index 2: WORD_W=8, SPI_MODE=1
//   Each instance has its own sclk/cs. mosi and reset are shared.
//
// Timing
//   All stimulus changes land on multiples of 10 ns, midway between rising
//   clock edges, so no change races a synchroniser flop.
//
// Echo checks
//   The echo checks follow SPI_SLAVE_RX_ECHO_EN.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int HALF = 250;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [2:0]  sclk_v = 3'b010;
  logic [2:0]  cs_v = 3'b111;
  logic [2:0]  ready_v = 3'b000;
  logic [2:0]  miso_v;
  logic [2:0]  valid_v;
  logic [2:0]  ovf_v;
  logic [2:0]  ferr_v;
  logic [15:0] data0;
  logic [7:0]  data3;
  logic [7:0]  data1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] popped_q[$];
  int          ovf_cnt  = 0;
  int          ferr_cnt = 0;

  always #5 clock = ~clock;

  spi_slave_rx #(.WORD_W(16), .FIFO_DEPTH(4), .SPI_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .spi_sclk(sclk_v[0]), .spi_mosi(spi_mosi),
    .spi_cs(cs_v[0]), .spi_miso(miso_v[0]), .out_data(data0),
    .out_valid(valid_v[0]), .out_ready(ready_v[0]), .overflow(ovf_v[0]),
    .frame_err(ferr_v[0])
  );

  spi_slave_rx #(.WORD_W(8), .FIFO_DEPTH(4), .SPI_MODE(3)) dut3 (
    .clock(clock), .reset(reset), .spi_sclk(sclk_v[1]), .spi_mosi(spi_mosi),
    .spi_cs(cs_v[1]), .spi_miso(miso_v[1]), .out_data(data3),
    .out_valid(valid_v[1]), .out_ready(ready_v[1]), .overflow(ovf_v[1]),
    .frame_err(ferr_v[1])
  );

  spi_slave_rx #(.WORD_W(8), .FIFO_DEPTH(4), .SPI_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .spi_sclk(sclk_v[2]), .spi_mosi(spi_mosi),
    .spi_cs(cs_v[2]), .spi_miso(miso_v[2]), .out_data(data1),
    .out_valid(valid_v[2]), .out_ready(ready_v[2]), .overflow(ovf_v[2]),
    .frame_err(ferr_v[2])
  );

  // Scoreboard for instance 0. The pop is evaluated with pre-edge values.
  always @(posedge clock) begin
    if (valid_v[0] && ready_v[0]) popped_q.push_back(data0);
    if (ovf_v[0]) ovf_cnt++;
    if (ferr_v[0]) ferr_cnt++;
  end

  // Master: shifts nbits of word (MSB first) and captures miso at each of
  // its own sampling edges.
  task automatic spi_word(input int which, input int mode, input logic [31:0] word,
                          input int nbits, output logic [31:0] miso_word);
    logic pol;
    logic pha;
    pol = ((mode & 2) != 0);
    pha = ((mode & 1) != 0);
    miso_word = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!pha) begin
        spi_mosi = word[i];
        #HALF;
        miso_word = {miso_word[30:0], miso_v[which]};
        sclk_v[which] = ~pol;
        #HALF;
        sclk_v[which] = pol;
      end else begin
        sclk_v[which] = ~pol;
        spi_mosi = word[i];
        #HALF;
        miso_word = {miso_word[30:0], miso_v[which]};
        sclk_v[which] = pol;
        #HALF;
      end
    end
  endtask

  task automatic cs_low(input int which);
    cs_v[which] = 1'b0;
    #200;
  endtask

  task automatic cs_high(input int which);
    #200;
    cs_v[which] = 1'b1;
    #200;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #50;
    reset = 1'b0;
    n_tests++;
    if (valid_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 000", valid_v);
    end
    n_tests++;
    if (data0 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0000", data0);
    end
    n_tests++;
    if ({ovf_v, ferr_v, miso_v} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000000", {ovf_v, ferr_v, miso_v});
    end
    $display("[TB] reset: valid=%b data0=%h", valid_v, data0);
  endtask

  task automatic test_stream;
    logic [15:0] exp_w[4] = '{16'h0000, 16'h0000, 16'h0064, 16'h0064};
    logic [31:0] m;
    ready_v[0] = 1'b1;
    popped_q.delete();
    ovf_cnt = 0;
    cs_low(0);
    for (int w = 0; w < 4; w++) spi_word(0, 0, {16'h0, exp_w[w]}, 16, m);
    cs_high(0);
    #100;
    n_tests++;
    if (popped_q.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d expected 4", popped_q.size());
    end
    for (int w = 0; w < 4; w++) begin
      if (w < popped_q.size()) begin
        n_tests++;
        if (popped_q[w] !== exp_w[w]) begin
          n_fail++;
          $display("FAIL stream_word%0d: got %h expected %h", w, popped_q[w], exp_w[w]);
        end
        $display("[TB] stream word %0d: got %h expected %h", w, popped_q[w], exp_w[w]);
      end
    end
    n_tests++;
    if (ovf_cnt != 0) begin
      n_fail++;
      $display("FAIL stream_overflow: got %0d expected 0", ovf_cnt);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] m;
    ready_v[0] = 1'b0;
    popped_q.delete();
    ovf_cnt = 0;
    cs_low(0);
    for (int w = 1; w <= 6; w++) spi_word(0, 0, w, 16, m);
    cs_high(0);
    n_tests++;
    if (ovf_cnt != 2) begin
      n_fail++;
      $display("FAIL ovf_pulses: got %0d expected 2", ovf_cnt);
    end
    n_tests++;
    if (valid_v[0] !== 1'b1 || data0 !== 16'h0001) begin
      n_fail++;
      $display("FAIL ovf_head: got valid=%b data=%h expected 1/0001", valid_v[0], data0);
    end
    ready_v[0] = 1'b1;
    #100;
    n_tests++;
    if (popped_q.size() != 4) begin
      n_fail++;
      $display("FAIL ovf_drain_count: got %0d expected 4", popped_q.size());
    end
    for (int w = 0; w < 4; w++) begin
      if (w < popped_q.size()) begin
        n_tests++;
        if (popped_q[w] !== 16'(w + 1)) begin
          n_fail++;
          $display("FAIL ovf_drain%0d: got %h expected %h", w, popped_q[w], 16'(w + 1));
        end
        $display("[TB] drain word %0d: got %h", w, popped_q[w]);
      end
    end
    n_tests++;
    if (valid_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty: got valid=%b expected 0", valid_v[0]);
    end
  endtask

  task automatic test_frame_err;
    logic [31:0] m;
    ready_v[0] = 1'b1;
    popped_q.delete();
    ferr_cnt = 0;
    cs_low(0);
    spi_word(0, 0, 32'h0064 >> 7, 9, m);
    cs_high(0);
    n_tests++;
    if (ferr_cnt != 1 || popped_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_err: got pulses=%0d pushes=%0d expected 1/0", ferr_cnt, popped_q.size());
    end
    cs_low(0);
    spi_word(0, 0, 32'h1234, 16, m);
    cs_high(0);
    n_tests++;
    if (popped_q.size() != 1 || ferr_cnt != 1) begin
      n_fail++;
      $display("FAIL frame_recover_count: got pushes=%0d pulses=%0d expected 1/1", popped_q.size(), ferr_cnt);
    end else begin
      n_tests++;
      if (popped_q[0] !== 16'h1234) begin
        n_fail++;
        $display("FAIL frame_recover: got %h expected 1234", popped_q[0]);
      end
      $display("[TB] frame recover: got %h", popped_q[0]);
    end
  endtask

  task automatic test_modes;
    logic [31:0] m;
    cs_low(1);
    spi_word(1, 3, 32'hA5, 8, m);
    cs_high(1);
    n_tests++;
    if (valid_v[1] !== 1'b1 || data3 !== 8'hA5) begin
      n_fail++;
      $display("FAIL mode3: got valid=%b data=%h expected 1/a5", valid_v[1], data3);
    end
    $display("[TB] mode3: got %h", data3);
    cs_low(2);
    spi_word(2, 1, 32'h5A, 8, m);
    cs_high(2);
    n_tests++;
    if (valid_v[2] !== 1'b1 || data1 !== 8'h5A) begin
      n_fail++;
      $display("FAIL mode1: got valid=%b data=%h expected 1/5a", valid_v[2], data1);
    end
    $display("[TB] mode1: got %h", data1);
  endtask

  task automatic test_latency;
    logic [31:0] m;
    ready_v[0] = 1'b0;
    cs_low(0);
    spi_word(0, 0, 32'hABCD >> 1, 15, m);
    spi_mosi = 1'b1;
    #HALF;
    n_tests++;
    if (valid_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pre: got valid=%b expected 0", valid_v[0]);
    end
    sclk_v[0] = 1'b1;
    #40;
    n_tests++;
    if (valid_v[0] !== 1'b1 || data0 !== 16'hABCD) begin
      n_fail++;
      $display("FAIL latency: got valid=%b data=%h expected 1/abcd", valid_v[0], data0);
    end
    $display("[TB] latency: valid=%b data=%h", valid_v[0], data0);
    #210;
    sclk_v[0] = 1'b0;
    cs_high(0);
    ready_v[0] = 1'b1;
    #50;
    popped_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [31:0] m;
    ready_v[0] = 1'b1;
    popped_q.delete();
    ferr_cnt = 0;
    cs_low(0);
    spi_word(0, 0, 32'h5A, 7, m);
    reset = 1'b1;
    #10;
    n_tests++;
    if (valid_v !== 3'b000 || data0 !== 16'h0 || data3 !== 8'h0 || data1 !== 8'h0) begin
      n_fail++;
      $display("FAIL midreset_data: got valid=%b d0=%h d3=%h d1=%h expected all 0",
               valid_v, data0, data3, data1);
    end
    n_tests++;
    if ({ovf_v, ferr_v, miso_v} !== 9'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b expected 000000000", {ovf_v, ferr_v, miso_v});
    end
    reset = 1'b0;
    cs_high(0);
    cs_low(0);
    spi_word(0, 0, 32'hBEEF, 16, m);
    cs_high(0);
    n_tests++;
    if (popped_q.size() != 1 || ferr_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_recover_count: got pushes=%0d pulses=%0d expected 1/0", popped_q.size(), ferr_cnt);
    end else begin
      n_tests++;
      if (popped_q[0] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL midreset_recover: got %h expected beef", popped_q[0]);
      end
      $display("[TB] after mid reset: got %h", popped_q[0]);
    end
  endtask

  task automatic test_echo;
    logic [31:0] m1;
    logic [31:0] m2;
    reset = 1'b1;
    #50;
    reset = 1'b0;
    cs_low(0);
    spi_word(0, 0, 32'h0064, 16, m1);
    spi_word(0, 0, 32'h00FF, 16, m2);
    cs_high(0);
`ifdef SPI_SLAVE_RX_ECHO_EN
    n_tests++;
    if (m1[15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL echo_word1: got %h expected 0000", m1[15:0]);
    end
    n_tests++;
    if (m2[15:0] !== 16'h0064) begin
      n_fail++;
      $display("FAIL echo_word2: got %h expected 0064", m2[15:0]);
    end
`else
    n_tests++;
    if (m1[15:0] !== 16'h0000 || m2[15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL miso_tied: got %h/%h expected 0000/0000", m1[15:0], m2[15:0]);
    end
`endif
    $display("[TB] echo: word1 miso=%h word2 miso=%h", m1[15:0], m2[15:0]);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_frame_err();
    test_modes();
    test_latency();
    test_reset_mid();
    test_echo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning bits per received word (range 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0..3 (CPOL = bit 1, CPHA = bit 0).
REQ-004 SHALL have port clock, input, 1 bit: the single system clock; all logic sits on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port spi_sclk, input, 1 bit: SPI clock, asynchronous to clock.
REQ-007 SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-008 SHALL have port spi_cs, input, 1 bit: chip select, active-low.
REQ-009 SHALL have port spi_miso, output, 1 bit: serial data out (see Configuration).
REQ-010 SHALL have port out_data, output, WORD_W bits: FIFO head word.
REQ-011 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the head word.
REQ-013 SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when cs deasserts mid-word.

Function
REQ-015 SHALL pass spi_sclk, spi_mosi and spi_cs through 2-flop synchronisers; edges are detected on the synchronised sclk.
REQ-016 SHALL sample mosi on the synchronised rising sclk edge when CPOL xor CPHA = 0, otherwise on the falling edge; the opposite edge is the launch edge.
REQ-017 SHALL use a two-state FSM: IDLE (cs high), ACTIVE (cs low); IDLE->ACTIVE on synchronised cs low, ACTIVE->IDLE on synchronised cs high.
REQ-018 SHALL, in ACTIVE, shift each sampled bit in at the LSB and increment the bit counter (0..WORD_W-1), ignoring edges while in IDLE.
REQ-019 SHALL, on the WORD_W-th sample, push the word to the FIFO, clear the bit counter and stay in ACTIVE, so back-to-back words need no cs toggle.
REQ-020 SHALL, on ACTIVE->IDLE with bit counter nonzero, discard the partial word and pulse frame_err for one cycle; with counter zero, no pulse.
REQ-021 SHALL assert out_valid on the clock cycle after the push, at most 4 clock cycles after the raw sclk sampling edge.
REQ-022 SHALL pop the head when out_valid and out_ready are both 1; out_data is stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; otherwise the word is dropped and overflow pulses once.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH, using a count of log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
REQ-025 SHALL operate correctly when the clock frequency is at least 4x the sclk frequency; slower clocks are unsupported.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set FSM=IDLE, bit counter=0, shift register=0, FIFO empty, out_valid=0, out_data=0, overflow=0, frame_err=0, spi_miso=0, and synchroniser flops to idle levels (cs=1, sclk=CPOL).
REQ-027 SHALL abandon any partial word when reset is applied mid-transfer, without pulsing frame_err.

Configuration
REQ-028 SHALL gate the MISO echo feature with macro SPI_SLAVE_RX_ECHO_EN.
REQ-029 SHALL, with SPI_SLAVE_RX_ECHO_EN defined, load a TX register with the most recently completed word (0 after reset) on ACTIVE entry and at each word boundary.
REQ-030 SHALL, with SPI_SLAVE_RX_ECHO_EN defined, shift the TX register out MSB first on launch edges (for CPHA=0 the MSB is presented at load), driving spi_miso only in ACTIVE and 0 otherwise.
REQ-031 SHALL, without SPI_SLAVE_RX_ECHO_EN, tie spi_miso to 0 and synthesise no TX register.

Verification
REQ-032 SHALL cover: mode 0, WORD_W=16, cs low, sclk 500 ns period, clock 10 ns, words 0x0000,0x0000,0x0064,0x0064 with out_ready=1 -> four out_valid pulses with those values in order, overflow=0.
REQ-033 SHALL cover: out_ready=0, FIFO_DEPTH=4, six words 0x0001..0x0006 -> first four retained, overflow pulses twice; draining yields 0x0001..0x0004.
REQ-034 SHALL cover: cs raised after 9 bits of 0x0064 -> frame_err one pulse, no push; the next full word 0x1234 is received correctly.
REQ-035 SHALL cover: SPI_MODE=3, WORD_W=8, byte 0xA5 -> out_data=0xA5; SPI_MODE=1, byte 0x5A -> out_data=0x5A.
REQ-036 SHALL cover: echo enabled, send 0x0064 then 0x00FF -> miso carries 0x0000 during word 1 and 0x0064 during word 2.
REQ-037 SHALL cover: reset asserted after 7 bits -> all outputs at reset values next cycle; a subsequent 0xBEEF is received intact.
